// File: rtl/shift_pkg.sv
// Shared encodings, FSM state type and defaults for the shift_ctrl iterative shifter.
package shift_pkg;

  localparam logic [3:0] FUNCT3_SLL = 4'b0001;
  localparam logic [3:0] FUNCT3_SRL = 4'b0101;
  localparam logic [3:0] FUNCT3_SRA = 4'b1101;

  localparam int STEP_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic funct_supported(input logic [3:0] funct);
    return (funct == FUNCT3_SLL) || (funct == FUNCT3_SRL) || (funct == FUNCT3_SRA);
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Two-port request bus plus single response channel of the shared shifter.
interface shift_ctrl_if;

  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][3:0]  req_funct_i;
  logic [1:0][31:0] req_op1_i;
  logic [1:0][31:0] req_op2_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_id_o;
  logic [31:0]      rsp_res_o;
  logic             busy_o;

  modport slave (
    input  req_valid_i, req_funct_i, req_op1_i, req_op2_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_res_o, busy_o
  );

  modport master (
    output req_valid_i, req_funct_i, req_op1_i, req_op2_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_res_o, busy_o
  );

endinterface

// File: rtl/shift_step.sv
// Combinational 32-bit shift by 0..STEP positions; the amount port is only as wide as STEP needs.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic [3:0]                   funct_i,
  input  logic [31:0]                  data_i,
  input  logic [$clog2(STEP + 1)-1:0]  amt_i,
  output logic [31:0]                  data_o
);

  always_comb begin
    data_o = data_i;
    case (funct_i)
      FUNCT3_SLL: data_o = data_i << amt_i;
      FUNCT3_SRL: data_o = data_i >> amt_i;
      FUNCT3_SRA: data_o = $unsigned($signed(data_i) >>> amt_i);
      default:    data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_ctrl.sv
// Round-robin two-port shift controller iterating a narrow shifter STEP bits per cycle.
// Defining SHIFT_CTRL_FAST_EN computes the whole shift on the accept edge instead.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  shift_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  amt_q, amt_d;
  logic [3:0]  funct_q, funct_d;
  logic        id_q, id_d;

  logic        grant_any;
  logic        grant_id;
  logic [31:0] step_out;

  // The favoured port only matters when both ask at once.
  always_comb begin
    grant_any = |bus.req_valid_i;
    grant_id  = (&bus.req_valid_i) ? ptr_q : bus.req_valid_i[1];
  end

  always_comb begin
    bus.req_ready_o = 2'b00;
    if ((state_q == IDLE) && rst_n_i && grant_any) begin
      bus.req_ready_o[grant_id] = 1'b1;
    end
  end

`ifndef SHIFT_CTRL_FAST_EN
  localparam int         SAW      = $clog2(STEP + 1);
  localparam logic [4:0] STEP_AMT = 5'(STEP);

  logic [4:0] step_amt;

  assign step_amt = (amt_q > STEP_AMT) ? STEP_AMT : amt_q;

  shift_step #(.STEP(STEP)) u_step (
    .funct_i (funct_q),
    .data_i  (acc_q),
    .amt_i   (step_amt[SAW-1:0]),
    .data_o  (step_out)
  );
`else
  // Full-width shifter fed straight from the granted port so the result lands on the accept edge.
  shift_step #(.STEP(31)) u_step (
    .funct_i (bus.req_funct_i[grant_id]),
    .data_i  (bus.req_op1_i[grant_id]),
    .amt_i   (bus.req_op2_i[grant_id][4:0]),
    .data_o  (step_out)
  );
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    funct_d = funct_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          ptr_d   = ~grant_id;
          id_d    = grant_id;
          funct_d = bus.req_funct_i[grant_id];
`ifdef SHIFT_CTRL_FAST_EN
          acc_d   = step_out;
          amt_d   = 5'd0;
          state_d = DONE;
`else
          acc_d   = bus.req_op1_i[grant_id];
          amt_d   = bus.req_op2_i[grant_id][4:0];
          if ((bus.req_op2_i[grant_id][4:0] == 5'd0) ||
              !funct_supported(bus.req_funct_i[grant_id])) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
`endif
        end
      end
`ifndef SHIFT_CTRL_FAST_EN
      SHIFT: begin
        acc_d = step_out;
        amt_d = amt_q - step_amt;
        if (amt_q == step_amt) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (bus.rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      acc_q   <= 32'd0;
      amt_q   <= 5'd0;
      funct_q <= 4'd0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      funct_q <= funct_d;
      id_q    <= id_d;
    end
  end

  assign bus.rsp_valid_o = (state_q == DONE);
  assign bus.rsp_res_o   = acc_q;
  assign bus.rsp_id_o    = id_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: doc/shift_ctrl.md
# shift_ctrl

Multi-cycle controller that shares one narrow shift datapath between two requesters (port 0: execute stage, port 1: secondary requester such as address or CSR logic). It arbitrates round-robin, accepts one operation at a time and iterates the shift in steps of at most STEP bits per cycle. It returns the 32-bit result on a valid/ready response channel. It sits beside the ALU in the execute stage and replaces a full 32-bit barrel shifter where area matters.

## Interface
- STEP, default 8: maximum shift distance applied per SHIFT cycle; power of two, 1..16.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- req_valid_i  input  2  per-port request valid.
- req_ready_o  output  2  per-port accept; at most one bit high.
- req_funct_i  input  2x4  per-port operation code: FUNCT3_SLL, FUNCT3_SRL or FUNCT3_SRA.
- req_op1_i  input  2x32  per-port data operand.
- req_op2_i  input  2x32  per-port shift amount; only bits [4:0] are used.
- rsp_valid_o  output  1  result valid.
- rsp_ready_i  input  1  consumer accepts result.
- rsp_id_o  output  1  port index of the request that produced the result.
- rsp_res_o  output  32  shift result.
- busy_o  output  1  high whenever state is not IDLE.

## Operation
- Operations:
  - SLL: logical left shift.
  - SRL: logical right shift.
  - SRA: arithmetic right shift, replicating bit 31.
  - Any other funct value: result = op1 unchanged.
- States and transitions:
  - IDLE: grant one valid port. req_ready_o[g] is high combinationally in the same cycle. On that edge, capture acc=op1, amt=op2[4:0], funct and id=g.
    - Next state is DONE if amt==0 or funct is unsupported; otherwise SHIFT.
  - SHIFT: each cycle, acc is shifted by s=min(amt,STEP) and amt decrements by s. When amt reaches 0 → DONE.
  - DONE: rsp_valid_o=1. rsp_res_o and rsp_id_o hold stable until rsp_ready_i. On the handshake edge → IDLE.
- Requests are never accepted outside IDLE. There is no overlap of response and new accept, so the minimum spacing between accepts is 2 cycles.
- Arbitration:
  - A 1-bit priority pointer selects the favoured port, which wins when both are valid. Otherwise the single valid port wins.
  - After every grant, pointer = ~g.
- Requesters hold valid and operands stable until ready. Dropping valid before ready is illegal and need not be tolerated.
- Reset values: state IDLE, pointer 0, acc 0, amt 0, rsp_valid_o 0, rsp_res_o 0, rsp_id_o 0, busy_o 0, req_ready_o 0 while reset is asserted.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation. The result is discarded, and there is no response after reset release.

## Timing
- Accept in cycle T with amount a: rsp_valid_o first high in cycle T+1+ceil(a/STEP).
  - a=0 or unsupported funct: rsp_valid_o high in T+1.
  - STEP=8, a=31: rsp_valid_o high in T+5.
- busy_o is high from T+1 until the cycle after the response handshake.
- req_ready_o depends on req_valid_i and state only, never on rsp_ready_i.

## Configuration
- SHIFT_CTRL_FAST_EN:
  - Defined: the full shift is computed on the accept edge and the controller goes directly IDLE→DONE. Latency is always 1 cycle, the SHIFT state is unreachable, and STEP is ignored.
  - Undefined: iterative behaviour as above.
- Arbitration, handshake and response behaviour are identical either way.

## Structure
- shift_pkg holds:
  - the FUNCT3_SLL/SRL/SRA encodings;
  - the state enum (IDLE, SHIFT, DONE);
  - the default STEP value.
- Sub-module shift_step: combinational 32-bit shift by 0..STEP under funct. It is instantiated once; under SHIFT_CTRL_FAST_EN it is instantiated with STEP=31.

## Test plan
- Port 0 SLL, op1=0x0000_0001, op2=31, STEP=8 → rsp_res_o=0x8000_0000, rsp_id_o=0, rsp_valid_o 5 cycles after accept.
- Port 1 SRA, op1=0x8000_0000, op2=0x24 (amt 4) → rsp_res_o=0xF800_0000, id=1, after 2 cycles. The same operation with SRL → 0x0800_0000.
- Both ports valid continuously from reset, 4 operations → grant order 0,1,0,1. Only port 1 valid, then both → order 1,0.
- rsp_ready_i low for 3 cycles in DONE → rsp_valid_o, rsp_res_o and rsp_id_o stable, req_ready_o=0, busy_o=1; the handshake then returns the block to IDLE.
- op2=0 or funct=0xF with op1=0xDEAD_BEEF → result 0xDEAD_BEEF, 1 cycle after accept.
- rst_n_i pulsed low during SHIFT → all outputs at reset values immediately, no response emitted, and the next request is served correctly with port 0 favoured.
